// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU/immediate/writeback enums
// and the funct3-to-ALU-operation mapping used by both register and immediate ops.
package rv32i_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4} wb_sel_e;

  // alt_sub selects SUB for funct3 000 (register form only); alt_sra selects SRA for 101
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3,
                                            input logic alt_sub,
                                            input logic alt_sra);
    alu_op_e op;
    case (f3)
      F3_ADD:  op = alt_sub ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt_sra ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit ALU; shift amounts use the low 5 bits of b.
module rv32i_alu
  import rv32i_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  // Select the result of the requested operation
  always_comb begin
    y = 32'h0000_0000;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << b[4:0];
      ALU_SLT:    y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU:   y = {31'd0, (a < b)};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> b[4:0];
      ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv32i_mem.sv
// Byte-wide memory with a combinational little-endian 32-bit read port and
// per-lane synchronous writes. Lane addresses wrap within the 16-bit space.
// Contents are never reset so backdoor-loaded images survive reset.
module rv32i_mem #(
  parameter int MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic [15:0] addr,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [15:0] addr1;
  logic [15:0] addr2;
  logic [15:0] addr3;

  // Lane addresses, wrapping mod 64 KiB
  always_comb begin
    addr1 = addr + 16'd1;
    addr2 = addr + 16'd2;
    addr3 = addr + 16'd3;
  end

  // Assemble the little-endian word starting at addr
  always_comb begin
    rdata = {mem[addr3], mem[addr2], mem[addr1], mem[addr]};
  end

  // Write each enabled byte lane at the clock edge
  always_ff @(posedge clk) begin
    if (we[0]) mem[addr]  <= wdata[7:0];
    if (we[1]) mem[addr1] <= wdata[15:8];
    if (we[2]) mem[addr2] <= wdata[23:16];
    if (we[3]) mem[addr3] <= wdata[31:24];
  end

endmodule

// File: rtl/rv32i_regfile.sv
// 32x32 register file, two combinational read ports, one write port.
// x0 always reads as zero regardless of what its storage holds.
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] registers [0:31];

  // Reset clears x1..x31; otherwise write rd unless it is x0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) registers[i] <= 32'h0000_0000;
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  // Read ports with x0 hardwired to zero
  always_comb begin
    if (raddr1 == 5'd0) rdata1 = 32'h0000_0000;
    else                rdata1 = registers[raddr1];
    if (raddr2 == 5'd0) rdata2 = 32'h0000_0000;
    else                rdata2 = registers[raddr2];
  end

endmodule

// File: rtl/rv32i_top.sv
// Single-cycle RV32I core: fetch, inline decode/immediate/branch logic, ALU,
// register file and separate instruction/data byte memories.
module rv32i_top
  import rv32i_pkg::*;
#(
  parameter int          MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_y;
  logic [31:0] dm_rdata;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic [3:0]  store_we;
  logic [3:0]  dm_we;
  logic        reg_we;
  logic        a_is_pc;
  logic        b_is_imm;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic        taken;
  alu_op_e     alu_op;
  imm_type_e   imm_type;
  wb_sel_e     wb_sel;

  rv32i_mem #(.MEM_BYTES(MEM_BYTES)) im (
    .clk   (clk),
    .addr  (pc[15:0]),
    .we    (4'b0000),
    .wdata (32'h0000_0000),
    .rdata (instr)
  );

  rv32i_mem #(.MEM_BYTES(MEM_BYTES)) dm (
    .clk   (clk),
    .addr  (alu_y[15:0]),
    .we    (dm_we),
    .wdata (rs2_val),
    .rdata (dm_rdata)
  );

  rv32i_regfile regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we),
    .waddr  (rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  rv32i_alu alu (
    .op (alu_op),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  // Instruction fields
  always_comb begin
    opcode   = instr[6:0];
    rd       = instr[11:7];
    funct3   = instr[14:12];
    rs1      = instr[19:15];
    rs2      = instr[24:20];
    pc_plus4 = pc + 32'd4;
  end

  // Main decoder: unknown opcodes (FENCE/SYSTEM included) keep all enables low
  always_comb begin
    alu_op    = ALU_ADD;
    imm_type  = IMM_I;
    a_is_pc   = 1'b0;
    b_is_imm  = 1'b1;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    store_we  = 4'b0000;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U;
        alu_op   = ALU_PASS_B;
        reg_we   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U;
        a_is_pc  = 1'b1;
        reg_we   = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        reg_we   = 1'b1;
        wb_sel   = WB_PC4;
        is_jal   = 1'b1;
      end
      OPC_JALR: begin
        reg_we  = 1'b1;
        wb_sel  = WB_PC4;
        is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = 1'b1;
      end
      OPC_LOAD: begin
        reg_we = 1'b1;
        wb_sel = WB_LOAD;
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        case (funct3)
          F3_SB:   store_we = 4'b0001;
          F3_SH:   store_we = 4'b0011;
          F3_SW:   store_we = 4'b1111;
          default: store_we = 4'b0000;
        endcase
      end
      OPC_OP_IMM: begin
        alu_op = alu_op_decode(funct3, 1'b0, instr[30]);
        reg_we = 1'b1;
      end
      OPC_OP: begin
        alu_op   = alu_op_decode(funct3, instr[30], instr[30]);
        b_is_imm = 1'b0;
        reg_we   = 1'b1;
      end
      default: begin
        reg_we = 1'b0;
      end
    endcase
  end

  // Immediate generation for the five encodings
  always_comb begin
    case (imm_type)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
  end

  // ALU operand selection
  always_comb begin
    if (a_is_pc) alu_a = pc;
    else         alu_a = rs1_val;
    if (b_is_imm) alu_b = imm;
    else          alu_b = rs2_val;
  end

  // Branch comparison
  always_comb begin
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Next-PC selection; misaligned targets are followed as-is
  always_comb begin
    if (is_jal || (is_branch && taken)) next_pc = pc + imm;
    else if (is_jalr)                   next_pc = alu_y & 32'hFFFF_FFFE;
    else                                next_pc = pc_plus4;
  end

  // Load extraction and sign/zero extension
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
      F3_LH:   load_data = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
      F3_LW:   load_data = dm_rdata;
      F3_LBU:  load_data = {24'd0, dm_rdata[7:0]};
      F3_LHU:  load_data = {16'd0, dm_rdata[15:0]};
      default: load_data = dm_rdata;
    endcase
  end

  // Writeback source and store suppression while reset is asserted
  always_comb begin
    case (wb_sel)
      WB_ALU:  wb_data = alu_y;
      WB_LOAD: wb_data = load_data;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
    if (rst) dm_we = 4'b0000;
    else     dm_we = store_we;
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

endmodule

// File: tb/tb_rv32i_top.sv
// Bench for rv32i_top: a directed program with hand-derived results, then random
// programs run in lockstep against an instruction-level reference model,
// including a one-cycle reset in the middle of a run.
module tb_rv32i_top;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_im [0:65535];
  logic [7:0]  m_dm [0:65535];
  logic [31:0] m_x  [0:31];
  logic [31:0] m_pc;

  rv32i_top dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_t(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_t(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                      logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                      logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] u_t(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_t(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;

  task automatic put_word(input logic [15:0] a, input logic [31:0] w);
    m_im[a]         = w[7:0];
    m_im[a + 16'd1] = w[15:8];
    m_im[a + 16'd2] = w[23:16];
    m_im[a + 16'd3] = w[31:24];
  endtask

  task automatic clear_images();
    for (int i = 0; i < 65536; i++) begin
      m_im[i] = 8'h00;
      m_dm[i] = 8'h00;
    end
  endtask

  task automatic load_images();
    for (int i = 0; i < 65536; i++) begin
      dut.im.mem[i] = m_im[i];
      dut.dm.mem[i] = m_dm[i];
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endtask

  // Reference: execute one instruction from the architectural rules
  task automatic model_step();
    logic [31:0] ins, rs1v, rs2v, ii, is, ib, iu, ij, res, npc, ea, w;
    logic [15:0] a, e;
    logic [4:0]  sh;
    logic        wr, tk;
    int          n;
    a    = m_pc[15:0];
    ins  = {m_im[a + 16'd3], m_im[a + 16'd2], m_im[a + 16'd1], m_im[a]};
    rs1v = m_x[ins[19:15]];
    rs2v = m_x[ins[24:20]];
    ii   = {{20{ins[31]}}, ins[31:20]};
    is   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu   = {ins[31:12], 12'h000};
    ij   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc  = m_pc + 32'd4;
    res  = 32'h0;
    wr   = 1'b0;
    tk   = 1'b0;
    case (ins[6:0])
      7'b0110111: begin res = iu; wr = 1'b1; end
      7'b0010111: begin res = m_pc + iu; wr = 1'b1; end
      7'b1101111: begin res = m_pc + 32'd4; wr = 1'b1; npc = m_pc + ij; end
      7'b1100111: begin res = m_pc + 32'd4; wr = 1'b1; npc = (rs1v + ii) & 32'hFFFF_FFFE; end
      7'b1100011: begin
        case (ins[14:12])
          3'd0:    tk = (rs1v == rs2v);
          3'd1:    tk = (rs1v != rs2v);
          3'd4:    tk = ($signed(rs1v) <  $signed(rs2v));
          3'd5:    tk = ($signed(rs1v) >= $signed(rs2v));
          3'd6:    tk = (rs1v <  rs2v);
          3'd7:    tk = (rs1v >= rs2v);
          default: tk = 1'b0;
        endcase
        if (tk) npc = m_pc + ib;
      end
      7'b0000011: begin
        ea = rs1v + ii;
        e  = ea[15:0];
        w  = {m_dm[e + 16'd3], m_dm[e + 16'd2], m_dm[e + 16'd1], m_dm[e]};
        case (ins[14:12])
          3'd0:    res = {{24{w[7]}}, w[7:0]};
          3'd1:    res = {{16{w[15]}}, w[15:0]};
          3'd4:    res = {24'd0, w[7:0]};
          3'd5:    res = {16'd0, w[15:0]};
          default: res = w;
        endcase
        wr = 1'b1;
      end
      7'b0100011: begin
        ea = rs1v + is;
        e  = ea[15:0];
        case (ins[14:12])
          3'd0:    n = 1;
          3'd1:    n = 2;
          3'd2:    n = 4;
          default: n = 0;
        endcase
        for (int k = 0; k < n; k++) m_dm[e + 16'(k)] = rs2v[8*k +: 8];
      end
      7'b0010011, 7'b0110011: begin
        logic [31:0] bv;
        bv = (ins[6:0] == 7'b0010011) ? ii : rs2v;
        sh = bv[4:0];
        wr = 1'b1;
        case (ins[14:12])
          3'd0: res = (ins[5] && ins[30]) ? rs1v - bv : rs1v + bv;
          3'd1: res = rs1v << sh;
          3'd2: res = ($signed(rs1v) < $signed(bv)) ? 32'd1 : 32'd0;
          3'd3: res = (rs1v < bv) ? 32'd1 : 32'd0;
          3'd4: res = rs1v ^ bv;
          3'd5: res = ins[30] ? $unsigned($signed(rs1v) >>> sh) : rs1v >> sh;
          3'd6: res = rs1v | bv;
          default: res = rs1v & bv;
        endcase
      end
      default: ;
    endcase
    if (wr && (ins[11:7] != 5'd0)) m_x[ins[11:7]] = res;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3, pf;
    logic [11:0] imm;
    int          kind, pick;
    rd   = 5'($urandom_range(1, 30));
    rs1  = 5'($urandom_range(0, 31));
    rs2  = 5'($urandom_range(0, 31));
    f3   = 3'($urandom_range(0, 7));
    imm  = 12'($urandom);
    kind = $urandom_range(0, 11);
    case (kind)
      0, 1, 2:
        return r_t(((f3 == 3'd0) || (f3 == 3'd5)) ? {1'b0, 1'($urandom_range(0, 1)), 5'd0} : 7'd0,
                   rs2, rs1, f3, rd);
      3, 4, 5: begin
        if (f3 == 3'd1)      imm = {7'd0, rs2};
        else if (f3 == 3'd5) imm = {1'b0, 1'($urandom_range(0, 1)), 5'd0, rs2};
        return i_t(imm, rs1, f3, rd, OPI);
      end
      6: return u_t(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'b0110111 : 7'b0010111);
      7, 8: begin
        pick = $urandom_range(0, 4);
        pf   = 3'((pick < 3) ? pick : pick + 1);
        return i_t(12'($urandom_range(0, 255)), 5'd31, pf, rd, LD);
      end
      9: return s_t(12'($urandom_range(0, 255)), rs2, 5'd31, 3'($urandom_range(0, 2)));
      10: begin
        pick = $urandom_range(0, 5);
        pf   = 3'((pick < 2) ? pick : pick + 2);
        return b_t(13'd8, rs2, rs1, pf);
      end
      default: return j_t(21'd8, 5'($urandom_range(0, 30)));
    endcase
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_regs(input string tag);
    for (int k = 1; k < 32; k++) check($sformatf("%s_x%0d", tag, k), dut.regfile.registers[k], m_x[k]);
  endtask

  task automatic check_dm_region(input string tag);
    for (int a = 16'h9000; a < 16'h9108; a += 4)
      check($sformatf("%s_dm%h", tag, a[15:0]),
            {dut.dm.mem[a + 3], dut.dm.mem[a + 2], dut.dm.mem[a + 1], dut.dm.mem[a]},
            {m_dm[a + 3], m_dm[a + 2], m_dm[a + 1], m_dm[a]});
  endtask

  // Lockstep run from a negedge until the completion byte is stored
  task automatic run_prog(input int max_cycles, input int reset_at);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && (cyc < max_cycles)) begin
      check("pc", dut.pc, m_pc);
      if (cyc == reset_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midreset_pc", dut.pc, 32'h0);
        check_regs("midreset");
        check_dm_region("midreset");
      end else begin
        model_step();
        if (m_dm[16'hFFFC] == 8'hFF) done = 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
      cyc++;
    end
    check("completed", {31'd0, done}, 32'd1);
    check("done_byte", {24'd0, dut.dm.mem[16'hFFFC]}, 32'h0000_00FF);
  endtask

  initial begin
    // ---------- directed program ----------
    clear_images();
    put_word(16'h00, i_t(12'hFFF, 5'd0, 3'd0, 5'd1, OPI));
    put_word(16'h04, i_t(12'h004, 5'd1, 3'd5, 5'd2, OPI));
    put_word(16'h08, i_t(12'h404, 5'd1, 3'd5, 5'd3, OPI));
    put_word(16'h0C, r_t(7'h00, 5'd1, 5'd0, 3'd3, 5'd4));
    put_word(16'h10, j_t(21'd8, 5'd1));
    put_word(16'h14, i_t(12'h001, 5'd0, 3'd0, 5'd8, OPI));
    put_word(16'h18, r_t(7'h00, 5'd3, 5'd0, 3'd2, 5'd5));
    put_word(16'h1C, u_t(20'h12345, 5'd9, 7'b0110111));
    put_word(16'h20, u_t(20'h00001, 5'd10, 7'b0010111));
    put_word(16'h24, i_t(12'h005, 5'd0, 3'd0, 5'd0, OPI));
    put_word(16'h28, r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd6));
    put_word(16'h2C, u_t(20'h80FF8, 5'd11, 7'b0110111));
    put_word(16'h30, i_t(12'hF01, 5'd11, 3'd0, 5'd11, OPI));
    put_word(16'h34, u_t(20'h00009, 5'd12, 7'b0110111));
    put_word(16'h38, s_t(12'h000, 5'd11, 5'd12, 3'd2));
    put_word(16'h3C, i_t(12'h000, 5'd12, 3'd0, 5'd13, LD));
    put_word(16'h40, i_t(12'h001, 5'd12, 3'd0, 5'd14, LD));
    put_word(16'h44, i_t(12'h003, 5'd12, 3'd4, 5'd15, LD));
    put_word(16'h48, i_t(12'h002, 5'd12, 3'd1, 5'd16, LD));
    put_word(16'h4C, i_t(12'h0AA, 5'd0, 3'd0, 5'd17, OPI));
    put_word(16'h50, s_t(12'h001, 5'd17, 5'd12, 3'd0));
    put_word(16'h54, i_t(12'h000, 5'd12, 3'd2, 5'd18, LD));
    put_word(16'h58, b_t(13'd8, 5'd0, 5'd4, 3'd0));
    put_word(16'h5C, b_t(13'd8, 5'd0, 5'd4, 3'd1));
    put_word(16'h60, i_t(12'h001, 5'd0, 3'd0, 5'd19, OPI));
    put_word(16'h64, b_t(13'd8, 5'd0, 5'd3, 3'd4));
    put_word(16'h68, i_t(12'h002, 5'd19, 3'd0, 5'd19, OPI));
    put_word(16'h6C, b_t(13'd8, 5'd3, 5'd0, 3'd7));
    put_word(16'h70, i_t(12'h003, 5'd0, 3'd0, 5'd20, OPI));
    put_word(16'h74, b_t(13'd8, 5'd0, 5'd3, 3'd7));
    put_word(16'h78, i_t(12'h007, 5'd0, 3'd0, 5'd20, OPI));
    put_word(16'h7C, b_t(13'd8, 5'd3, 5'd0, 3'd4));
    put_word(16'h80, b_t(13'd8, 5'd0, 5'd0, 3'd1));
    put_word(16'h84, b_t(13'd8, 5'd0, 5'd0, 3'd0));
    put_word(16'h88, i_t(12'h009, 5'd0, 3'd0, 5'd20, OPI));
    put_word(16'h8C, i_t(12'h09B, 5'd0, 3'd0, 5'd21, OPI));
    put_word(16'h90, i_t(12'h002, 5'd21, 3'd0, 5'd22, 7'b1100111));
    put_word(16'h94, i_t(12'h00B, 5'd0, 3'd0, 5'd20, OPI));
    put_word(16'h98, i_t(12'h00B, 5'd0, 3'd0, 5'd20, OPI));
    put_word(16'h9C, i_t(12'hFFF, 5'd0, 3'd0, 5'd23, OPI));
    put_word(16'hA0, s_t(12'hFFC, 5'd23, 5'd0, 3'd0));
    put_word(16'hA4, j_t(21'd0, 5'd0));
    load_images();
    dut.regfile.registers[0] = 32'hDEAD_BEEF;
    reset_dut();
    check("reset_pc", dut.pc, 32'h0);
    check_regs("reset");
    run_prog(2000, -1);
    check("srli_x2",  dut.regfile.registers[2],  32'h0FFF_FFFF);
    check("srai_x3",  dut.regfile.registers[3],  32'hFFFF_FFFF);
    check("sltu_x4",  dut.regfile.registers[4],  32'h0000_0001);
    check("slt_x5",   dut.regfile.registers[5],  32'h0000_0000);
    check("x0_x6",    dut.regfile.registers[6],  32'h0000_0000);
    check("jal_x1",   dut.regfile.registers[1],  32'h0000_0014);
    check("jal_skip", dut.regfile.registers[8],  32'h0000_0000);
    check("lui_x9",   dut.regfile.registers[9],  32'h1234_5000);
    check("auipc",    dut.regfile.registers[10], 32'h0000_1020);
    check("lb0",      dut.regfile.registers[13], 32'h0000_0001);
    check("lb1",      dut.regfile.registers[14], 32'h0000_007F);
    check("lbu3",     dut.regfile.registers[15], 32'h0000_0080);
    check("lh2",      dut.regfile.registers[16], 32'hFFFF_80FF);
    check("sb_lw",    dut.regfile.registers[18], 32'h80FF_AA01);
    check("br_skip",  dut.regfile.registers[19], 32'h0000_0000);
    check("br_path",  dut.regfile.registers[20], 32'h0000_0003);
    check("jalr_x22", dut.regfile.registers[22], 32'h0000_0094);
    check("final_pc", dut.pc, 32'h0000_00A4);
    check("dm9000", {dut.dm.mem[16'h9003], dut.dm.mem[16'h9002], dut.dm.mem[16'h9001],
                     dut.dm.mem[16'h9000]}, 32'h80FF_AA01);
    check_regs("dir");

    // ---------- random program ----------
    rst = 1'b1;
    clear_images();
    put_word(16'h0000, u_t(20'h00009, 5'd31, 7'b0110111));
    for (int i = 1; i <= 300; i++) put_word(16'(4 * i), rand_instr());
    put_word(16'(4 * 301), 32'h0000_0013);
    put_word(16'(4 * 302), 32'h0000_0013);
    put_word(16'(4 * 303), i_t(12'hFFF, 5'd0, 3'd0, 5'd30, OPI));
    put_word(16'(4 * 304), s_t(12'hFFC, 5'd30, 5'd0, 3'd0));
    put_word(16'(4 * 305), j_t(21'd0, 5'd0));
    for (int i = 16'h9000; i < 16'h9200; i++) m_dm[i] = 8'($urandom);
    load_images();
    reset_dut();
    run_prog(2000, -1);
    check_regs("rnd");
    check_dm_region("rnd");

    // ---------- same program, reset mid-run ----------
    rst = 1'b1;
    for (int i = 16'h9000; i < 16'h9200; i++) m_dm[i] = 8'($urandom);
    m_dm[16'hFFFC] = 8'h00;
    load_images();
    reset_dut();
    run_prog(2000, 60);
    check_regs("rst");
    check_dm_region("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
